// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register:
//   - XLEN_DEFAULT : default datapath width
//   - ALUOP_*      : ALUOp encodings carried in the control bundle
//   - ctrl_t       : decoded control bundle (MSB..LSB field order below)
//   - BUBBLE       : control value of an inserted no-op
//   - halt_state_e : halt FSM states
//   - is_ebreak()  : true for a valid instruction that requests a halt
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   // 14-bit bundle; field order fixes the packed bit layout
   typedef struct packed {
      logic       branch;      // [13]
      logic       MemtoReg;    // [12]
      logic       MemRead;     // [11]
      logic       MemWrite;    // [10]
      logic       ALUSrc;      // [9]
      logic       RegWrite;    // [8]
      logic       jalr;        // [7]
      logic       auipc;       // [6]
      logic       jal;         // [5]
      logic       lui;         // [4]
      logic       isnot_halt;  // [3]
      logic [1:0] ALUOp;       // [2:1]
      logic       valid;       // [0]
   } ctrl_t;

   // A bubble must not look like a halt request, hence isnot_halt=1
   localparam ctrl_t BUBBLE = '{
      branch:     1'b0,
      MemtoReg:   1'b0,
      MemRead:    1'b0,
      MemWrite:   1'b0,
      ALUSrc:     1'b0,
      RegWrite:   1'b0,
      jalr:       1'b0,
      auipc:      1'b0,
      jal:        1'b0,
      lui:        1'b0,
      isnot_halt: 1'b1,
      ALUOp:      ALUOP_ADD,
      valid:      1'b0
   };

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } halt_state_e;

   function automatic logic is_ebreak(input ctrl_t c);
      return c.valid & ~c.isnot_halt;
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard compare between the instruction held in EX
// and the instruction currently in decode.
//   ex_mem_read_i : EX instruction is a load
//   ex_valid_i    : EX slot holds a real instruction (not a bubble)
//   ex_rd_i       : EX destination register
//   id_rs1_i/rs2_i: decode source registers
//   hazard_o      : decode instruction must wait one cycle
// -----------------------------------------------------------------------------
module hazard_detect (
   input  logic       ex_mem_read_i,
   input  logic       ex_valid_i,
   input  logic [4:0] ex_rd_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   output logic       hazard_o
);

   // x0 is hard-wired zero, so a load into it never produces a dependency
   assign hazard_o = ex_mem_read_i & ex_valid_i & (ex_rd_i != 5'd0) &
                     ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall, flush and sticky EBREAK halt.
//   clk, rst            : clock, asynchronous active-high reset
//   id_ctrl             : decoded control bundle from decode
//   id_pc..id_imm       : decode PC, register reads, immediate (XLEN)
//   id_rs1/rs2/rd       : register specifiers; id_funct3, id_inst30
//   ex_flush            : redirect resolved in EX, kills decode instruction
//   ex_*                : registered copies of the id_* inputs
//   stall_o             : hold PC and IF/ID this cycle
//   halted_o            : EBREAK has entered EX (sticky until reset)
// Edge priority: halted > ex_flush > hazard > normal capture.
// -----------------------------------------------------------------------------
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  ctrl_t           id_ctrl,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [2:0]      id_funct3,
   input  logic            id_inst30,
   input  logic            ex_flush,
   output ctrl_t           ex_ctrl,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [2:0]      ex_funct3,
   output logic            ex_inst30,
   output logic            stall_o,
   output logic            halted_o
);

   halt_state_e     state_q, state_d;
   ctrl_t           ctrl_q, ctrl_d;
   logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;
   logic [2:0]      funct3_q;
   logic            inst30_q;
   logic            hazard;
   logic            capture;

   hazard_detect u_hazard_detect (
      .ex_mem_read_i (ctrl_q.MemRead),
      .ex_valid_i    (ctrl_q.valid),
      .ex_rd_i       (rd_q),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .hazard_o      (hazard)
   );

   // State and pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         ctrl_q     <= BUBBLE;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         funct3_q   <= '0;
         inst30_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         // Data registers only move on a real capture; otherwise they hold
         if (capture) begin
            pc_q       <= id_pc;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
            funct3_q   <= id_funct3;
            inst30_q   <= id_inst30;
         end
      end
   end

   // Next-state: only an EBREAK that is actually captured enters HALTED
   always_comb begin
      state_d = state_q;
      if (state_q == RUN && !ex_flush && !hazard && is_ebreak(id_ctrl)) begin
         state_d = HALTED;
      end
   end

   // Outputs and EX control selection
   always_comb begin
      stall_o  = 1'b0;
      halted_o = 1'b0;
      capture  = 1'b0;
      ctrl_d   = BUBBLE;
      unique case (state_q)
         RUN: begin
            if (ex_flush) begin
               ctrl_d = BUBBLE;
            end else if (hazard) begin
               ctrl_d  = BUBBLE;
               stall_o = 1'b1;
            end else begin
               capture = 1'b1;
               ctrl_d  = id_ctrl;
               // The halting instruction lingers one cycle in EX; keep it
               // from touching architectural state
               if (is_ebreak(id_ctrl)) begin
                  ctrl_d.RegWrite = 1'b0;
                  ctrl_d.MemWrite = 1'b0;
               end
            end
         end
         HALTED: begin
            ctrl_d   = BUBBLE;
            stall_o  = 1'b1;
            halted_o = 1'b1;
         end
         default: begin
            ctrl_d = BUBBLE;
         end
      endcase
   end

   assign ex_ctrl     = ctrl_q;
   assign ex_pc       = pc_q;
   assign ex_rs1_data = rs1_data_q;
   assign ex_rs2_data = rs2_data_q;
   assign ex_imm      = imm_q;
   assign ex_rs1      = rs1_q;
   assign ex_rs2      = rs2_q;
   assign ex_rd       = rd_q;
   assign ex_funct3   = funct3_q;
   assign ex_inst30   = inst30_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Table-driven bench for id_ex_stage with a scoreboard queue of expected
// post-edge results, plus hand-written asynchronous reset sequences.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   // Control encodings {branch,MemtoReg,MemRead,MemWrite,ALUSrc,RegWrite,
   //                    jalr,auipc,jal,lui,isnot_halt,ALUOp[1:0],valid}
   localparam logic [13:0] C_BUB  = 14'h0008;  // bubble
   localparam logic [13:0] C_R    = 14'h010D;  // R-type: RegWrite, ALUOp=10
   localparam logic [13:0] C_LW   = 14'h1B09;  // load
   localparam logic [13:0] C_ECL  = 14'h0009;  // ECALL: no halt
   localparam logic [13:0] C_EBK  = 14'h0101;  // EBREAK with stray RegWrite
   localparam logic [13:0] C_EBKX = 14'h0001;  // EBREAK as seen in EX

   typedef struct {
      logic        flush;
      logic [13:0] ctrl;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        exp_stall;
      logic [13:0] exp_ctrl;
      logic [31:0] exp_pc;
      logic [4:0]  exp_rs1, exp_rs2, exp_rd;
      logic        exp_halted;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] id_ctrl;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_funct3;
   logic        id_inst30, ex_flush;
   logic [13:0] ex_ctrl;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_inst30, stall_o, halted_o;

   int n_vec = 0;
   int n_err = 0;
   vec_t sb[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_ctrl     (id_ctrl),
      .id_pc       (id_pc),
      .id_rs1_data (id_rs1_data),
      .id_rs2_data (id_rs2_data),
      .id_imm      (id_imm),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_rd       (id_rd),
      .id_funct3   (id_funct3),
      .id_inst30   (id_inst30),
      .ex_flush    (ex_flush),
      .ex_ctrl     (ex_ctrl),
      .ex_pc       (ex_pc),
      .ex_rs1_data (ex_rs1_data),
      .ex_rs2_data (ex_rs2_data),
      .ex_imm      (ex_imm),
      .ex_rs1      (ex_rs1),
      .ex_rs2      (ex_rs2),
      .ex_rd       (ex_rd),
      .ex_funct3   (ex_funct3),
      .ex_inst30   (ex_inst30),
      .stall_o     (stall_o),
      .halted_o    (halted_o)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic [13:0] c, input logic [31:0] pc,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                               input logic es, input logic [13:0] ec, input logic [31:0] ep,
                               input logic [4:0] er1, input logic [4:0] er2, input logic [4:0] erd,
                               input logic eh);
      vec_t v;
      v.flush = fl; v.ctrl = c; v.pc = pc; v.rs1 = r1; v.rs2 = r2; v.rd = rd;
      v.exp_stall = es; v.exp_ctrl = ec; v.exp_pc = ep;
      v.exp_rs1 = er1; v.exp_rs2 = er2; v.exp_rd = erd; v.exp_halted = eh;
      return v;
   endfunction

   // Data fields are tied to pc/rd so held vs. captured values are visible
   task automatic drive(input vec_t v);
      ex_flush    = v.flush;
      id_ctrl     = v.ctrl;
      id_pc       = v.pc;
      id_rs1_data = 32'(v.pc * 5);
      id_rs2_data = 32'(v.pc * 7);
      id_imm      = 32'(v.pc * 3);
      id_rs1      = v.rs1;
      id_rs2      = v.rs2;
      id_rd       = v.rd;
      id_funct3   = v.rd[2:0];
      id_inst30   = v.rd[3];
   endtask

   task automatic check_post(input vec_t e);
      chk("ex_ctrl", 128'(ex_ctrl), 128'(e.exp_ctrl));
      chk("ex_pc", 128'(ex_pc), 128'(e.exp_pc));
      chk("ex_rs1_rs2_rd", 128'({ex_rs1, ex_rs2, ex_rd}), 128'({e.exp_rs1, e.exp_rs2, e.exp_rd}));
      chk("halted_o", 128'(halted_o), 128'(e.exp_halted));
      chk("ex_data", 128'({ex_imm, ex_rs1_data, ex_rs2_data, ex_funct3, ex_inst30}),
          128'({32'(e.exp_pc * 3), 32'(e.exp_pc * 5), 32'(e.exp_pc * 7),
                e.exp_rd[2:0], e.exp_rd[3]}));
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      drive(v);
      sb.push_back(v);
      #1 chk("stall_o", 128'(stall_o), 128'(v.exp_stall));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_post(e);
      $display("vec pc=%08h flush=%0b -> ex_pc=%08h ex_ctrl=%04h stall=%0b halted=%0b",
               v.pc, v.flush, ex_pc, ex_ctrl, v.exp_stall, halted_o);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ex_ctrl"}, 128'(ex_ctrl), 128'(C_BUB));
      chk({tag, "_ex_pc"}, 128'(ex_pc), 128'(0));
      chk({tag, "_ex_rd"}, 128'(ex_rd), 128'(0));
      chk({tag, "_halted"}, 128'(halted_o), 128'(0));
      chk({tag, "_stall"}, 128'(stall_o), 128'(0));
   endtask

   initial begin
      vec_t v;
      drive(mk(0, C_BUB, 0, 0, 0, 0, 0, C_BUB, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1 check_reset_vals("reset");
      @(negedge clk);
      rst = 1'b0;

      //          fl ctrl   pc     rs1 rs2 rd | stall exp_ctrl exp_pc rs1 rs2 rd halted
      tbl.push_back(mk(0, C_R,   32'h00, 1, 2, 3,   0, C_R,    32'h00, 1, 2, 3,  0));
      tbl.push_back(mk(0, C_R,   32'h04, 3, 4, 7,   0, C_R,    32'h04, 3, 4, 7,  0));
      tbl.push_back(mk(0, C_LW,  32'h08, 1, 0, 5,   0, C_LW,   32'h08, 1, 0, 5,  0));
      tbl.push_back(mk(0, C_R,   32'h0C, 5, 1, 6,   1, C_BUB,  32'h08, 1, 0, 5,  0));
      tbl.push_back(mk(0, C_R,   32'h0C, 5, 1, 6,   0, C_R,    32'h0C, 5, 1, 6,  0));
      tbl.push_back(mk(0, C_LW,  32'h10, 2, 0, 0,   0, C_LW,   32'h10, 2, 0, 0,  0));
      tbl.push_back(mk(0, C_R,   32'h14, 0, 1, 6,   0, C_R,    32'h14, 0, 1, 6,  0));
      tbl.push_back(mk(0, C_LW,  32'h18, 1, 0, 9,   0, C_LW,   32'h18, 1, 0, 9,  0));
      tbl.push_back(mk(1, C_R,   32'h1C, 2, 9, 10,  0, C_BUB,  32'h18, 1, 0, 9,  0));
      tbl.push_back(mk(0, C_R,   32'h40, 9, 9, 11,  0, C_R,    32'h40, 9, 9, 11, 0));
      tbl.push_back(mk(0, C_ECL, 32'h44, 0, 0, 0,   0, C_ECL,  32'h44, 0, 0, 0,  0));
      tbl.push_back(mk(1, C_EBK, 32'h48, 0, 0, 0,   0, C_BUB,  32'h44, 0, 0, 0,  0));
      tbl.push_back(mk(0, C_LW,  32'h4C, 1, 0, 12,  0, C_LW,   32'h4C, 1, 0, 12, 0));
      tbl.push_back(mk(0, C_EBK, 32'h50, 12, 0, 0,  1, C_BUB,  32'h4C, 1, 0, 12, 0));
      tbl.push_back(mk(0, C_EBK, 32'h20, 0, 0, 0,   0, C_EBKX, 32'h20, 0, 0, 0,  1));
      // Halted: everything held regardless of flush or new instructions
      for (int i = 0; i < 12; i++) begin
         tbl.push_back(mk(i[0], (i % 3 == 0) ? C_LW : C_R, 32'h60 + 32'(4 * i), 5'(i), 3, 4,
                          1, C_BUB, 32'h20, 0, 0, 0, 1));
      end
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i]);
      end

      // Asynchronous reset while halted, then normal capture resumes
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals("rst_halted");
      #1 rst = 1'b0;
      step(mk(0, C_R, 32'h100, 1, 2, 3, 0, C_R, 32'h100, 1, 2, 3, 0));

      // Asynchronous reset during a load-use stall
      step(mk(0, C_LW, 32'h104, 1, 0, 5, 0, C_LW, 32'h104, 1, 0, 5, 0));
      v = mk(0, C_R, 32'h108, 5, 1, 6, 0, C_R, 32'h108, 5, 1, 6, 0);
      @(negedge clk);
      drive(v);
      #1 chk("stall_pre_rst", 128'(stall_o), 128'(1));
      #1 rst = 1'b1;
      #1 check_reset_vals("rst_stall");
      #1 rst = 1'b0;
      @(posedge clk);
      #1 check_post(v);
      $display("vec pc=%08h after reset release -> ex_pc=%08h ex_ctrl=%04h", v.pc, ex_pc, ex_ctrl);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
